// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

  // Prefetch buffer entries and FIFO read-data latency in cycles
  localparam int BUF_DEPTH  = 3;
  localparam int RD_LATENCY = 1;

  // Buffer pointer / occupancy count (0..BUF_DEPTH)
  typedef logic [1:0] ptr_t;

  // Circular pointer increment, wrapping after BUF_DEPTH-1
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the reader.
// Latency: n/a (wires only).
// Backpressure: m_ready from the consumer; fifo_empty from the FIFO.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  import fifo_pkg::*;

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  ptr_t                  buf_count;

  // Reader side: drains the FIFO and drives the stream
  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, buf_count
  );

  // FIFO + consumer side
  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, buf_count
  );

endinterface

// File: rtl/fifo_stream_reader_prefetch_buf.sv
// 3-entry circular prefetch store with occupancy count.
// Latency: push visible at o_dout the cycle after the write edge.
// Backpressure: none internally; caller never pushes when full (pop same cycle allowed).
module fifo_prefetch_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout,
  output ptr_t                  o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  ptr_t                  r_wptr;
  ptr_t                  r_rptr;
  ptr_t                  r_occ;
  logic                  w_pop;
  logic                  w_push;

  // Pop only real data; a push into a full buffer is accepted only alongside a pop
  assign w_pop  = i_pop && (r_occ != ptr_t'(0));
  assign w_push = i_push && ((r_occ != ptr_t'(BUF_DEPTH)) || w_pop);

  // Storage is deliberately not reset; occupancy gates what is visible
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Pointers and occupancy; simultaneous push+pop leaves the count alone
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_dout = r_mem[r_rptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the FIFO read port into a 3-word prefetch buffer and emits a framed stream.
// Latency: first beat valid 2 cycles after the first fifo_rd_en; 1 word/cycle sustained.
// Backpressure: reads stop once buffered + in-flight words reach 3; m_ready never reaches fifo_rd_en.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16
) (
  input logic                  rclk,
  input logic                  rrst,
  fifo_stream_reader_if.master bus
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic                  r_inflight;
  logic [15:0]           r_beat;
  ptr_t                  w_occ;
  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [2:0]            w_committed;

  // Words already owned by the reader: buffered plus the one still on the FIFO data bus
  assign w_committed = {1'b0, w_occ} + (r_inflight ? 3'(RD_LATENCY) : 3'd0);
  assign w_rd_en     = !rrst && !bus.fifo_empty && (w_committed < 3'(BUF_DEPTH));

  assign w_valid = (w_occ != ptr_t'(0));
  assign w_pop   = w_valid && bus.m_ready;

  // Remember that the FIFO will present a word next cycle
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  // Position of the head word within its packet
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == LAST_BEAT) ? 16'd0 : r_beat + 16'd1;
    end
  end

  fifo_prefetch_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .i_clk (rclk),
    .i_rst (rrst),
    .i_push(r_inflight),
    .i_pop (w_pop),
    .i_din (bus.fifo_data),
    .o_dout(w_dout),
    .o_occ (w_occ)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_data     = w_dout;
  assign bus.m_valid    = w_valid;
  assign bus.m_last     = w_valid && (r_beat == LAST_BEAT);
  assign bus.buf_count  = w_occ;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: FIFO model feeding two readers (PKT_LEN 16 and 1) with a stream scoreboard.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();
  fifo_stream_reader_if #(.DATA_WIDTH(8)) bus1 ();

  fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(16)) dut (
    .rclk(rclk), .rrst(rrst), .bus(bus.master)
  );
  fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(1)) dut1 (
    .rclk(rclk), .rrst(rrst), .bus(bus1.master)
  );

  // The PKT_LEN=1 reader sees identical FIFO/consumer inputs
  assign bus1.fifo_empty = bus.fifo_empty;
  assign bus1.fifo_data  = bus.fifo_data;
  assign bus1.m_ready    = bus.m_ready;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int beat_m;
  int n_chk;
  int n_fail;
  int n_reads;
  int r0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic push_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(8'(first + i));
      exp_q.push_back(8'(first + i));
    end
    if (n > 0) bus.fifo_empty = 1'b0;
  endtask

  // Called at a negedge: per-cycle checks, then advance one clock and update the FIFO model
  task automatic cyc();
    logic       rd;
    logic [7:0] e;
    rd = bus.fifo_rd_en;
    if (rd) n_reads++;
    if (bus.fifo_empty) check_eq("rd_while_empty", 32'(rd), 32'd0);
    check_eq("p1_valid_match", 32'(bus1.m_valid), 32'(bus.m_valid));
    if (bus.m_valid && bus.m_ready) begin
      check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("m_data", 32'(bus.m_data), 32'(e));
        check_eq("m_last", 32'(bus.m_last), 32'(beat_m == 15));
        check_eq("p1_last", 32'(bus1.m_last), 32'd1);
        beat_m = (beat_m == 15) ? 0 : beat_m + 1;
      end
    end
    @(posedge rclk);
    #1;
    if (rd && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; n_reads = 0; beat_m = 0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 8'h00;
    bus.m_ready    = 1'b0;
    rrst = 1'b1;

    // Reset: outputs idle and no reads even with FIFO data waiting
    push_words(8'h01, 32);
    repeat (3) begin
      @(negedge rclk);
      check_eq("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check_eq("rst_valid", 32'(bus.m_valid), 32'd0);
      check_eq("rst_last", 32'(bus.m_last), 32'd0);
      check_eq("rst_count", 32'(bus.buf_count), 32'd0);
      cyc();
    end

    // Streaming 0x01..0x20: read in N, valid in N+2, then one word per cycle
    rrst = 1'b0;
    bus.m_ready = 1'b1;
    @(negedge rclk);
    check_eq("first_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    check_eq("first_valid_n", 32'(bus.m_valid), 32'd0);
    cyc();
    @(negedge rclk);
    check_eq("first_valid_n1", 32'(bus.m_valid), 32'd0);
    cyc();
    for (int i = 0; i < 32; i++) begin
      @(negedge rclk);
      check_eq("stream_valid", 32'(bus.m_valid), 32'd1);
      cyc();
    end
    @(negedge rclk);
    check_eq("stream_end_valid", 32'(bus.m_valid), 32'd0);
    check_eq("stream_all_seen", 32'(exp_q.size()), 32'd0);
    cyc();

    // Backpressure: 10 words available, exactly 3 reads, head word held
    bus.m_ready = 1'b0;
    push_words(8'h40, 10);
    r0 = n_reads;
    repeat (8) begin
      @(negedge rclk);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check_eq("bp_reads", 32'(n_reads - r0), 32'd3);
      check_eq("bp_count", 32'(bus.buf_count), 32'd3);
      check_eq("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
      check_eq("bp_valid", 32'(bus.m_valid), 32'd1);
      check_eq("bp_hold_data", 32'(bus.m_data), 32'h40);
      cyc();
    end

    // Release: no read while full, read reissues as soon as count drops, gap-free drain
    bus.m_ready = 1'b1;
    @(negedge rclk);
    check_eq("rel_full_count", 32'(bus.buf_count), 32'd3);
    check_eq("rel_no_rd", 32'(bus.fifo_rd_en), 32'd0);
    check_eq("rel_valid", 32'(bus.m_valid), 32'd1);
    cyc();
    @(negedge rclk);
    check_eq("rel_count2", 32'(bus.buf_count), 32'd2);
    check_eq("rel_rd_issue", 32'(bus.fifo_rd_en), 32'd1);
    check_eq("rel_valid", 32'(bus.m_valid), 32'd1);
    cyc();
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      check_eq("drain_valid", 32'(bus.m_valid), 32'd1);
      cyc();
    end
    // FIFO ran dry mid-stream: valid falls after the last buffered word
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check_eq("empty_valid", 32'(bus.m_valid), 32'd0);
      check_eq("empty_count", 32'(bus.buf_count), 32'd0);
      cyc();
    end
    check_eq("drain_all_seen", 32'(exp_q.size()), 32'd0);

    // Reset with two words buffered and a read in flight
    bus.m_ready = 1'b0;
    push_words(8'h80, 3);
    @(negedge rclk);
    check_eq("pre_rst_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    cyc();
    @(negedge rclk);
    cyc();
    @(negedge rclk);
    cyc();
    rrst = 1'b1;
    @(negedge rclk);
    check_eq("pre_rst_count", 32'(bus.buf_count), 32'd2);
    check_eq("rst_gate_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    cyc();
    rrst = 1'b0;
    exp_q.delete();
    beat_m = 0;
    @(negedge rclk);
    check_eq("post_rst_valid", 32'(bus.m_valid), 32'd0);
    check_eq("post_rst_count", 32'(bus.buf_count), 32'd0);
    check_eq("post_rst_last", 32'(bus.m_last), 32'd0);
    cyc();
    @(negedge rclk);
    check_eq("rst_inflight_drop", 32'(bus.buf_count), 32'd0);
    cyc();

    // After reset the beat counter restarts: 16th new word is last
    bus.m_ready = 1'b1;
    push_words(8'hA0, 20);
    repeat (30) begin
      @(negedge rclk);
      cyc();
    end
    check_eq("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
